// File: rtl/fma_norm_shift.sv
// fma_norm_shift: post-addition normalization shifter for the multi-precision
// FMA datapath. Counts leading zeros in each lane of the packed 106-bit sum
// and left-justifies each lane so its MSB is 1. The shift counts are returned
// for exponent adjustment.
//
// Lane packing (input and output):
//   mode 00/11 : one lane  [105:0]                               (width 106)
//   mode 01    : four lanes [21:0] [49:28] [77:56] [105:84]      (width 22)
//   mode 10    : two lanes  [47:0] [105:58]                      (width 48)
// Gap bits are ignored on input and forced to 0 on output. An all-zero lane
// reports lzc = lane width and sets its zero flag. Unused lanes report 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_sum (106), in_mode (2)
//   out_valid/out_ready output handshake
//   out_norm (106)      normalized lanes, same packing as in_sum
//   out_lzc0..3 (8)     per-lane shift count, lane 0 least significant
//   out_zero (4)        per-lane all-zero flag
//   out_mode (2)        in_mode carried with the beat
//
// Build option: FMA_NORM_PIPE2_EN
//   defined   : LZC in stage S1, shift in stage S2; 2-cycle latency, 2 beats
//   undefined : LZC and shift combinational into one output register;
//               1-cycle latency, 1 beat

module fma_norm_shift (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [105:0] in_sum,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [105:0] out_norm,
  output logic [7:0]   out_lzc0,
  output logic [7:0]   out_lzc1,
  output logic [7:0]   out_lzc2,
  output logic [7:0]   out_lzc3,
  output logic [3:0]   out_zero,
  output logic [1:0]   out_mode
);

  // Leading-zero count of a lane held in the low w bits of v.
  // Returns w when the lane is all zero.
  function automatic logic [7:0] lane_lzc(input logic [105:0] v, input int w);
    logic [7:0] n;
    logic       hit;
    n   = 8'(w);
    hit = 1'b0;
    for (int i = 105; i >= 0; i--) begin
      if (i < w && !hit && v[i]) begin
        n   = 8'(w - 1 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction

  // Shift each lane left by its own count inside the lane width; gaps stay 0.
  // A count equal to the lane width (zero lane) shifts everything out.
  function automatic logic [105:0] shift_lanes(input logic [105:0] s,
                                               input logic [1:0]   m,
                                               input logic [7:0]   l0,
                                               input logic [7:0]   l1,
                                               input logic [7:0]   l2,
                                               input logic [7:0]   l3);
    logic [105:0] r;
    logic [21:0]  q;
    logic [47:0]  h;
    r = '0;
    q = '0;
    h = '0;
    case (m)
      2'b01: begin
        q = s[21:0]   << l0;  r[21:0]   = q;
        q = s[49:28]  << l1;  r[49:28]  = q;
        q = s[77:56]  << l2;  r[77:56]  = q;
        q = s[105:84] << l3;  r[105:84] = q;
      end
      2'b10: begin
        h = s[47:0]   << l0;  r[47:0]   = h;
        h = s[105:58] << l1;  r[105:58] = h;
      end
      default: r = s << l0;
    endcase
    return r;
  endfunction

  // Per-lane leading-zero count and zero flags of the incoming beat
  logic [7:0] lzc_c [4];
  logic [3:0] zero_c;

  always_comb begin
    for (int k = 0; k < 4; k++) lzc_c[k] = 8'd0;
    zero_c = 4'd0;
    case (in_mode)
      2'b01: begin
        for (int k = 0; k < 4; k++) begin
          lzc_c[k]  = lane_lzc({84'd0, in_sum[28*k +: 22]}, 22);
          zero_c[k] = (in_sum[28*k +: 22] == 22'd0);
        end
      end
      2'b10: begin
        for (int k = 0; k < 2; k++) begin
          lzc_c[k]  = lane_lzc({58'd0, in_sum[58*k +: 48]}, 48);
          zero_c[k] = (in_sum[58*k +: 48] == 48'd0);
        end
      end
      default: begin
        lzc_c[0]  = lane_lzc(in_sum, 106);
        zero_c[0] = (in_sum == 106'd0);
      end
    endcase
  end

  logic s2_valid;
  assign out_valid = s2_valid;

`ifdef FMA_NORM_PIPE2_EN
  logic         s1_valid;
  logic [105:0] s1_sum;
  logic [1:0]   s1_mode;
  logic [7:0]   s1_lzc [4];
  logic [3:0]   s1_zero;
  logic         s2_load;

  // S2 can take a new beat when empty or when its beat leaves this cycle
  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_mode  <= '0;
      for (int k = 0; k < 4; k++) s1_lzc[k] <= 8'd0;
      s1_zero  <= '0;
      s2_valid <= 1'b0;
      out_norm <= '0;
      out_lzc0 <= '0;
      out_lzc1 <= '0;
      out_lzc2 <= '0;
      out_lzc3 <= '0;
      out_zero <= '0;
      out_mode <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sum  <= in_sum;
        s1_mode <= in_mode;
        for (int k = 0; k < 4; k++) s1_lzc[k] <= lzc_c[k];
        s1_zero <= zero_c;
      end
      if (s2_load) s2_valid <= s1_valid;
      // Output data only changes when a real beat moves in, so it holds under stall
      if (s2_load && s1_valid) begin
        out_norm <= shift_lanes(s1_sum, s1_mode, s1_lzc[0], s1_lzc[1], s1_lzc[2], s1_lzc[3]);
        out_lzc0 <= s1_lzc[0];
        out_lzc1 <= s1_lzc[1];
        out_lzc2 <= s1_lzc[2];
        out_lzc3 <= s1_lzc[3];
        out_zero <= s1_zero;
        out_mode <= s1_mode;
      end
    end
  end
`else
  assign in_ready = !s2_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_norm <= '0;
      out_lzc0 <= '0;
      out_lzc1 <= '0;
      out_lzc2 <= '0;
      out_lzc3 <= '0;
      out_zero <= '0;
      out_mode <= '0;
    end else begin
      if (in_ready) s2_valid <= in_valid;
      if (in_valid && in_ready) begin
        out_norm <= shift_lanes(in_sum, in_mode, lzc_c[0], lzc_c[1], lzc_c[2], lzc_c[3]);
        out_lzc0 <= lzc_c[0];
        out_lzc1 <= lzc_c[1];
        out_lzc2 <= lzc_c[2];
        out_lzc3 <= lzc_c[3];
        out_zero <= zero_c;
        out_mode <= in_mode;
      end
    end
  end
`endif

endmodule
